// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes (same values as
// the euc state encoding), fetch state encoding and instruction field layout.
`timescale 1ns/1ps
package ifu_pkg;

  // Opcodes 0..11 are issued to euc, 12..15 are executed inside the ifu.
  localparam logic [3:0] OP_LD     = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_ADDI   = 4'd4;
  localparam logic [3:0] OP_CMPLT  = 4'd5;
  localparam logic [3:0] OP_CMPEQ  = 4'd6;
  localparam logic [3:0] OP_CMPEQI = 4'd7;
  localparam logic [3:0] OP_SHFTR  = 4'd8;
  localparam logic [3:0] OP_SHFTL  = 4'd9;
  localparam logic [3:0] OP_INV    = 4'd10;
  localparam logic [3:0] OP_MVI    = 4'd11;
  localparam logic [3:0] OP_JMP    = 4'd12;
  localparam logic [3:0] OP_BRC    = 4'd13;
  localparam logic [3:0] OP_NOP    = 4'd14;
  localparam logic [3:0] OP_HALT   = 4'd15;

  localparam int N_ISSUE_OPS = 12;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LATCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } ifu_state_e;

  // Instruction field positions.
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int DST_BIT  = 11;
  localparam int SRC_BIT  = 10;
  localparam int RSVD_MSB = 9;
  localparam int RSVD_LSB = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;
  localparam int IMM_W    = 8;

endpackage

// File: rtl/ifu_decode.sv
// Opcode decoder: one-hot line per issuable opcode, plus a flag for the
// control-flow opcodes the ifu executes itself.
`timescale 1ns/1ps
module ifu_decode
  import ifu_pkg::*;
(
  input  logic [3:0]             opcode,
  output logic [N_ISSUE_OPS-1:0] id_vec,
  output logic                   is_local
);

  localparam logic [N_ISSUE_OPS-1:0] ID_ONE = {{(N_ISSUE_OPS-1){1'b0}}, 1'b1};

  // Map opcode to its one-hot line; local opcodes drive no line.
  always_comb begin
    id_vec   = {N_ISSUE_OPS{1'b0}};
    is_local = 1'b0;
    case (opcode)
      OP_JMP, OP_BRC, OP_NOP, OP_HALT: is_local = 1'b1;
      default:                         id_vec   = ID_ONE << opcode;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the pc, fetches from synchronous instruction
// memory, executes control flow locally and presents the rest to euc with a
// valid/done handshake. All outputs are decoded from registers only.
`timescale 1ns/1ps
module ifu
  import ifu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               instr_mem_rd_enb_o,
  output logic [PC_W-1:0]    instr_mem_addr_o,
  input  logic [INSTR_W-1:0] instr_mem_data_i,
  output logic               instr_valid_o,
  input  logic               instr_done_i,
  output logic               id_ld_o,
  output logic               id_and_o,
  output logic               id_str_o,
  output logic               id_add_o,
  output logic               id_addi_o,
  output logic               id_cmplt_o,
  output logic               id_cmpeq_o,
  output logic               id_cmpeqi_o,
  output logic               id_shftr_o,
  output logic               id_shftl_o,
  output logic               id_inv_o,
  output logic               id_mvi_o,
  output logic               src_reg_o,
  output logic               dst_reg_o,
  output logic [7:0]         imm_o,
  input  logic               cmp_flag_i,
  output logic               halted_o,
  output logic               proto_err_o
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  ifu_state_e             state_r;
  ifu_state_e             state_nx_s;
  logic [PC_W-1:0]        pc_r;
  logic [PC_W-1:0]        pc_nx_s;
  logic [PC_W-1:0]        pc_inc_s;
  logic [PC_W-1:0]        imm_tgt_s;
  logic [3:0]             op_in_s;
  logic [IMM_W-1:0]       imm_in_s;
  logic [N_ISSUE_OPS-1:0] id_vec_s;
  logic                   is_local_s;
  logic [N_ISSUE_OPS-1:0] id_r;
  logic                   dst_r;
  logic                   src_r;
  logic [IMM_W-1:0]       imm_r;
  logic                   proto_err_r;
  logic                   issue_s;
  logic                   rsvd_unused_s;

  assign op_in_s       = instr_mem_data_i[OPC_MSB:OPC_LSB];
  assign imm_in_s      = instr_mem_data_i[IMM_MSB:IMM_LSB];
  assign rsvd_unused_s = ^instr_mem_data_i[RSVD_MSB:RSVD_LSB];
  assign pc_inc_s      = pc_r + PC_ONE;

  // Jump/branch target: immediate zero-extended or truncated to the pc width.
  generate
    if (PC_W > IMM_W) begin : g_tgt_ext
      assign imm_tgt_s = {{(PC_W-IMM_W){1'b0}}, imm_in_s};
    end else if (PC_W == IMM_W) begin : g_tgt_eq
      assign imm_tgt_s = imm_in_s;
    end else begin : g_tgt_trunc
      assign imm_tgt_s = imm_in_s[PC_W-1:0];
    end
  endgenerate

  // Decode the word arriving from memory so the one-hot lines are registered in LATCH.
  ifu_decode u_decode (
    .opcode   (op_in_s),
    .id_vec   (id_vec_s),
    .is_local (is_local_s)
  );

  // Next state and pc: control flow is resolved in LATCH, issue retires on done.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    case (state_r)
      ST_FETCH: state_nx_s = ST_LATCH;
      ST_LATCH: begin
        if (is_local_s) begin
          case (op_in_s)
            OP_JMP: begin
              pc_nx_s    = imm_tgt_s;
              state_nx_s = ST_FETCH;
            end
            OP_BRC: begin
              if (cmp_flag_i) begin
                pc_nx_s = imm_tgt_s;
              end else begin
                pc_nx_s = pc_inc_s;
              end
              state_nx_s = ST_FETCH;
            end
            OP_NOP: begin
              pc_nx_s    = pc_inc_s;
              state_nx_s = ST_FETCH;
            end
            OP_HALT: state_nx_s = ST_HALT;
            default: state_nx_s = ST_FETCH;
          endcase
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_done_i) begin
          pc_nx_s    = pc_inc_s;
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_HALT: state_nx_s = ST_HALT;
      default: state_nx_s = ST_FETCH;
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      pc_r    <= {PC_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
    end
  end

  // Instruction fields and decode are captured only in LATCH so they stay put while issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_r  <= {N_ISSUE_OPS{1'b0}};
      dst_r <= 1'b0;
      src_r <= 1'b0;
      imm_r <= {IMM_W{1'b0}};
    end else if (state_r == ST_LATCH) begin
      id_r  <= id_vec_s;
      dst_r <= instr_mem_data_i[DST_BIT];
      src_r <= instr_mem_data_i[SRC_BIT];
      imm_r <= imm_in_s;
    end
  end

  // Sticky flag for a done that arrives while nothing is being issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      proto_err_r <= 1'b0;
    end else if (instr_done_i && (state_r != ST_ISSUE)) begin
      proto_err_r <= 1'b1;
    end
  end

  assign issue_s            = (state_r == ST_ISSUE);
  assign instr_mem_rd_enb_o = (state_r == ST_FETCH);
  assign instr_mem_addr_o   = pc_r;
  assign instr_valid_o      = issue_s;
  assign halted_o           = (state_r == ST_HALT);
  assign proto_err_o        = proto_err_r;
  assign src_reg_o          = src_r;
  assign dst_reg_o          = dst_r;
  assign imm_o              = imm_r;

  assign id_ld_o     = id_r[OP_LD]     & issue_s;
  assign id_and_o    = id_r[OP_AND]    & issue_s;
  assign id_str_o    = id_r[OP_STR]    & issue_s;
  assign id_add_o    = id_r[OP_ADD]    & issue_s;
  assign id_addi_o   = id_r[OP_ADDI]   & issue_s;
  assign id_cmplt_o  = id_r[OP_CMPLT]  & issue_s;
  assign id_cmpeq_o  = id_r[OP_CMPEQ]  & issue_s;
  assign id_cmpeqi_o = id_r[OP_CMPEQI] & issue_s;
  assign id_shftr_o  = id_r[OP_SHFTR]  & issue_s;
  assign id_shftl_o  = id_r[OP_SHFTL]  & issue_s;
  assign id_inv_o    = id_r[OP_INV]    & issue_s;
  assign id_mvi_o    = id_r[OP_MVI]    & issue_s;

endmodule
